// File: rtl/ysyx_22040365_idu_pkg.sv
// ysyx_22040365_idu_pkg
// Shared encodings for the decode stage and its consumers (EXU):
//   inst_type_e - instruction class code carried on out_type
//   alu_op_e    - ALU operation code carried on out_alu_op
//   imm_fmt_e   - immediate format select used inside the IDU
// plus the RV base opcodes and a funct3 -> ALU op helper.
package ysyx_22040365_idu_pkg;

    typedef enum logic [3:0] {
        INST_NONE    = 4'h0,   // reset / never-loaded bundle
        INST_ALU_I   = 4'h1,
        INST_ALU_R   = 4'h2,
        INST_LOAD    = 4'h3,
        INST_STORE   = 4'h4,
        INST_BRANCH  = 4'h5,
        INST_JAL     = 4'h6,
        INST_JALR    = 4'h7,
        INST_LUI     = 4'h8,
        INST_AUIPC   = 4'h9,
        INST_EBREAK  = 4'hA,
        INST_ILLEGAL = 4'hF
    } inst_type_e;

    typedef enum logic [4:0] {
        ALU_ADD  = 5'd0,
        ALU_SUB  = 5'd1,
        ALU_SLL  = 5'd2,
        ALU_SLT  = 5'd3,
        ALU_SLTU = 5'd4,
        ALU_XOR  = 5'd5,
        ALU_SRL  = 5'd6,
        ALU_SRA  = 5'd7,
        ALU_OR   = 5'd8,
        ALU_AND  = 5'd9,
        ALU_BEQ  = 5'd10,
        ALU_BNE  = 5'd11,
        ALU_BLT  = 5'd12,
        ALU_BGE  = 5'd13,
        ALU_BLTU = 5'd14,
        ALU_BGEU = 5'd15
    } alu_op_e;

    typedef enum logic [2:0] {
        IMM_NONE = 3'd0,
        IMM_I    = 3'd1,
        IMM_S    = 3'd2,
        IMM_B    = 3'd3,
        IMM_U    = 3'd4,
        IMM_J    = 3'd5
    } imm_fmt_e;

    localparam logic [6:0] OPC_LOAD     = 7'h03;
    localparam logic [6:0] OPC_OP_IMM   = 7'h13;
    localparam logic [6:0] OPC_AUIPC    = 7'h17;
    localparam logic [6:0] OPC_OP_IMM32 = 7'h1B;
    localparam logic [6:0] OPC_STORE    = 7'h23;
    localparam logic [6:0] OPC_OP       = 7'h33;
    localparam logic [6:0] OPC_LUI      = 7'h37;
    localparam logic [6:0] OPC_OP32     = 7'h3B;
    localparam logic [6:0] OPC_BRANCH   = 7'h63;
    localparam logic [6:0] OPC_JALR     = 7'h67;
    localparam logic [6:0] OPC_JAL      = 7'h6F;
    localparam logic [6:0] OPC_SYSTEM   = 7'h73;

    localparam logic [31:0] INST_WORD_EBREAK = 32'h0010_0073;

    // alt selects SUB over ADD and SRA over SRL (funct7 bit 5 / inst bit 30).
    function automatic alu_op_e alu_from_f3(input logic [2:0] f3, input logic alt);
        case (f3)
            3'b000:  return alt ? ALU_SUB : ALU_ADD;
            3'b001:  return ALU_SLL;
            3'b010:  return ALU_SLT;
            3'b011:  return ALU_SLTU;
            3'b100:  return ALU_XOR;
            3'b101:  return alt ? ALU_SRA : ALU_SRL;
            3'b110:  return ALU_OR;
            default: return ALU_AND;
        endcase
    endfunction

endpackage

// File: rtl/ysyx_22040365_imm_gen.sv
// ysyx_22040365_imm_gen
// Combinational immediate extraction and sign extension to XLEN.
//   inst_i [31:7] : instruction bits above the opcode
//   fmt_i         : immediate format (IMM_NONE yields 0)
//   imm_o         : sign-extended immediate, XLEN bits
module ysyx_22040365_imm_gen
    import ysyx_22040365_idu_pkg::*;
#(
    parameter int XLEN = 64
) (
    input  logic [31:7]     inst_i,
    input  imm_fmt_e        fmt_i,
    output logic [XLEN-1:0] imm_o
);

    logic [31:0] imm32;

    always_comb begin
        imm32 = '0;
        case (fmt_i)
            IMM_I: imm32 = {{20{inst_i[31]}}, inst_i[31:20]};
            IMM_S: imm32 = {{20{inst_i[31]}}, inst_i[31:25], inst_i[11:7]};
            IMM_B: imm32 = {{19{inst_i[31]}}, inst_i[31], inst_i[7],
                            inst_i[30:25], inst_i[11:8], 1'b0};
            IMM_U: imm32 = {inst_i[31:12], 12'b0};
            IMM_J: imm32 = {{11{inst_i[31]}}, inst_i[31], inst_i[19:12],
                            inst_i[20], inst_i[30:21], 1'b0};
            default: imm32 = '0;
        endcase
    end

    // Every format is already sign-extended to 32 bits; widen once more for RV64.
    generate
        if (XLEN == 64) begin : g_ext64
            assign imm_o = {{32{imm32[31]}}, imm32};
        end else begin : g_ext32
            assign imm_o = imm32;
        end
    endgenerate

endmodule

// File: rtl/ysyx_22040365_idu.sv
// ysyx_22040365_idu
// Pipelined RV32I/RV64I instruction decode with a single output register.
//   clk, rst_n          : core clock, async active-low reset
//   in_valid/in_ready   : IFU handshake; in_inst, in_pc carry the fetch
//   flush               : drops the held bundle and any incoming instruction
//   out_valid/out_ready : EXU handshake for the registered decode bundle
//   out_pc, out_type, out_alu_op, out_rs1/rs2/rd, out_ren_rs1/rs2,
//   out_wen_rd, out_imm, out_word : decoded fields
module ysyx_22040365_idu
    import ysyx_22040365_idu_pkg::*;
#(
    parameter int XLEN = 64
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic [31:0]     in_inst,
    input  logic [XLEN-1:0] in_pc,
    input  logic            flush,
    output logic            out_valid,
    input  logic            out_ready,
    output logic [XLEN-1:0] out_pc,
    output logic [3:0]      out_type,
    output logic [4:0]      out_alu_op,
    output logic [4:0]      out_rs1,
    output logic [4:0]      out_rs2,
    output logic [4:0]      out_rd,
    output logic            out_ren_rs1,
    output logic            out_ren_rs2,
    output logic            out_wen_rd,
    output logic [XLEN-1:0] out_imm,
    output logic            out_word
);

    localparam bit IS64 = (XLEN == 64);

    logic [6:0] opcode;
    logic [2:0] f3;
    logic [6:0] f7;
    logic [4:0] rd;

    assign opcode = in_inst[6:0];
    assign rd     = in_inst[11:7];
    assign f3     = in_inst[14:12];
    assign f7     = in_inst[31:25];

    inst_type_e      dec_type;
    alu_op_e         dec_alu;
    imm_fmt_e        dec_fmt;
    logic            dec_ren1, dec_ren2, dec_wen, dec_word, legal;
    logic [XLEN-1:0] dec_imm;

    always_comb begin
        dec_type = INST_ILLEGAL;
        dec_alu  = ALU_ADD;
        dec_fmt  = IMM_NONE;
        dec_ren1 = 1'b0;
        dec_ren2 = 1'b0;
        dec_wen  = 1'b0;
        dec_word = 1'b0;
        legal    = 1'b0;
        case (opcode)
            OPC_OP_IMM: begin
                dec_type = INST_ALU_I;
                dec_fmt  = IMM_I;
                dec_ren1 = 1'b1;
                dec_wen  = 1'b1;
                // inst[30] distinguishes SRAI only; ADDI with that bit set is still ADDI
                dec_alu  = alu_from_f3(f3, (f3 == 3'b101) && in_inst[30]);
                case (f3)
                    3'b001:  legal = (in_inst[31:26] == 6'b0) && (IS64 || !in_inst[25]);
                    3'b101:  legal = !in_inst[31] && (in_inst[29:26] == 4'b0)
                                     && (IS64 || !in_inst[25]);
                    default: legal = 1'b1;
                endcase
            end
            OPC_OP_IMM32: begin
                dec_type = INST_ALU_I;
                dec_fmt  = IMM_I;
                dec_ren1 = 1'b1;
                dec_wen  = 1'b1;
                dec_word = 1'b1;
                dec_alu  = alu_from_f3(f3, (f3 == 3'b101) && in_inst[30]);
                case (f3)
                    3'b000:  legal = IS64;
                    3'b001:  legal = IS64 && (f7 == 7'h00);
                    3'b101:  legal = IS64 && ((f7 == 7'h00) || (f7 == 7'h20));
                    default: legal = 1'b0;
                endcase
            end
            OPC_OP: begin
                dec_type = INST_ALU_R;
                dec_ren1 = 1'b1;
                dec_ren2 = 1'b1;
                dec_wen  = 1'b1;
                dec_alu  = alu_from_f3(f3, f7[5]);
                legal    = (f7 == 7'h00)
                        || ((f7 == 7'h20) && ((f3 == 3'b000) || (f3 == 3'b101)));
            end
            OPC_OP32: begin
                dec_type = INST_ALU_R;
                dec_ren1 = 1'b1;
                dec_ren2 = 1'b1;
                dec_wen  = 1'b1;
                dec_word = 1'b1;
                dec_alu  = alu_from_f3(f3, f7[5]);
                legal    = IS64 && (((f7 == 7'h00) && ((f3 == 3'b000) || (f3 == 3'b001)
                                                       || (f3 == 3'b101)))
                                 || ((f7 == 7'h20) && ((f3 == 3'b000) || (f3 == 3'b101))));
            end
            OPC_LOAD: begin
                dec_type = INST_LOAD;
                dec_fmt  = IMM_I;
                dec_ren1 = 1'b1;
                dec_wen  = 1'b1;
                legal    = (f3 == 3'b000) || (f3 == 3'b001) || (f3 == 3'b010)
                        || (f3 == 3'b100) || (f3 == 3'b101)
                        || (IS64 && ((f3 == 3'b011) || (f3 == 3'b110)));
            end
            OPC_STORE: begin
                dec_type = INST_STORE;
                dec_fmt  = IMM_S;
                dec_ren1 = 1'b1;
                dec_ren2 = 1'b1;
                legal    = (f3 <= 3'b010) || (IS64 && (f3 == 3'b011));
            end
            OPC_BRANCH: begin
                dec_type = INST_BRANCH;
                dec_fmt  = IMM_B;
                dec_ren1 = 1'b1;
                dec_ren2 = 1'b1;
                case (f3)
                    3'b000:  dec_alu = ALU_BEQ;
                    3'b001:  dec_alu = ALU_BNE;
                    3'b100:  dec_alu = ALU_BLT;
                    3'b101:  dec_alu = ALU_BGE;
                    3'b110:  dec_alu = ALU_BLTU;
                    default: dec_alu = ALU_BGEU;
                endcase
                legal = (f3 != 3'b010) && (f3 != 3'b011);
            end
            OPC_JAL: begin
                dec_type = INST_JAL;
                dec_fmt  = IMM_J;
                dec_wen  = 1'b1;
                legal    = 1'b1;
            end
            OPC_JALR: begin
                dec_type = INST_JALR;
                dec_fmt  = IMM_I;
                dec_ren1 = 1'b1;
                dec_wen  = 1'b1;
                legal    = (f3 == 3'b000);
            end
            OPC_LUI: begin
                dec_type = INST_LUI;
                dec_fmt  = IMM_U;
                dec_wen  = 1'b1;
                legal    = 1'b1;
            end
            OPC_AUIPC: begin
                dec_type = INST_AUIPC;
                dec_fmt  = IMM_U;
                dec_wen  = 1'b1;
                legal    = 1'b1;
            end
            OPC_SYSTEM: begin
                dec_type = INST_EBREAK;
                legal    = (in_inst == INST_WORD_EBREAK);
            end
            default: legal = 1'b0;
        endcase

        if (!legal) begin
            dec_type = INST_ILLEGAL;
            dec_alu  = ALU_ADD;
            dec_fmt  = IMM_NONE;
            dec_ren1 = 1'b0;
            dec_ren2 = 1'b0;
            dec_wen  = 1'b0;
            dec_word = 1'b0;
        end
        if (rd == 5'd0) begin
            dec_wen = 1'b0;
        end
    end

    ysyx_22040365_imm_gen #(
        .XLEN   (XLEN)
    ) u_imm_gen (
        .inst_i (in_inst[31:7]),
        .fmt_i  (dec_fmt),
        .imm_o  (dec_imm)
    );

    logic            out_valid_q, out_valid_d;
    logic [XLEN-1:0] out_pc_q, out_imm_q;
    logic [3:0]      out_type_q;
    logic [4:0]      out_alu_q, out_rs1_q, out_rs2_q, out_rd_q;
    logic            out_ren1_q, out_ren2_q, out_wen_q, out_word_q;
    logic            accept, load;

    assign in_ready = !out_valid_q || out_ready;
    assign accept   = in_valid && in_ready;
    // A flush in the same cycle as an accept drops the incoming instruction.
    assign load     = accept && !flush;

    always_comb begin
        if (flush) begin
            out_valid_d = 1'b0;
        end else if (accept) begin
            out_valid_d = 1'b1;
        end else if (out_ready) begin
            out_valid_d = 1'b0;
        end else begin
            out_valid_d = out_valid_q;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_valid_q <= 1'b0;
            out_pc_q    <= '0;
            out_imm_q   <= '0;
            out_type_q  <= '0;
            out_alu_q   <= '0;
            out_rs1_q   <= '0;
            out_rs2_q   <= '0;
            out_rd_q    <= '0;
            out_ren1_q  <= 1'b0;
            out_ren2_q  <= 1'b0;
            out_wen_q   <= 1'b0;
            out_word_q  <= 1'b0;
        end else begin
            out_valid_q <= out_valid_d;
            if (load) begin
                out_pc_q   <= in_pc;
                out_imm_q  <= dec_imm;
                out_type_q <= dec_type;
                out_alu_q  <= dec_alu;
                out_rs1_q  <= in_inst[19:15];
                out_rs2_q  <= in_inst[24:20];
                out_rd_q   <= rd;
                out_ren1_q <= dec_ren1;
                out_ren2_q <= dec_ren2;
                out_wen_q  <= dec_wen;
                out_word_q <= dec_word;
            end
        end
    end

    assign out_valid   = out_valid_q;
    assign out_pc      = out_pc_q;
    assign out_type    = out_type_q;
    assign out_alu_op  = out_alu_q;
    assign out_rs1     = out_rs1_q;
    assign out_rs2     = out_rs2_q;
    assign out_rd      = out_rd_q;
    assign out_ren_rs1 = out_ren1_q;
    assign out_ren_rs2 = out_ren2_q;
    assign out_wen_rd  = out_wen_q;
    assign out_imm     = out_imm_q;
    assign out_word    = out_word_q;

endmodule

// File: tb/tb_ysyx_22040365_idu.sv
// tb_ysyx_22040365_idu
// Directed bench: an RV64 and an RV32 IDU share the same inputs; expected
// values are hand-computed constants.
module tb_ysyx_22040365_idu;

    localparam logic [63:0] T_ALU_I = 64'h1, T_ALU_R = 64'h2, T_STORE = 64'h4,
                            T_BRANCH = 64'h5, T_JAL = 64'h6, T_LUI = 64'h8,
                            T_EBREAK = 64'hA, T_ILLEGAL = 64'hF;
    localparam logic [63:0] A_ADD = 64'd0, A_SUB = 64'd1, A_SRA = 64'd7, A_BEQ = 64'd10;

    logic        clk = 1'b0;
    logic        rst_n, in_valid, flush, out_ready;
    logic [31:0] in_inst;
    logic [63:0] in_pc;

    logic        rdy64, vld64, ren1_64, ren2_64, wen64, word64;
    logic [63:0] pc64, imm64;
    logic [3:0]  type64;
    logic [4:0]  alu64, rs1_64, rs2_64, rd64;

    logic        rdy32, vld32, ren1_32, ren2_32, wen32, word32;
    logic [31:0] pc32, imm32;
    logic [3:0]  type32;
    logic [4:0]  alu32, rs1_32, rs2_32, rd32;

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    ysyx_22040365_idu #(.XLEN(64)) dut64 (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(rdy64),
        .in_inst(in_inst), .in_pc(in_pc), .flush(flush), .out_valid(vld64),
        .out_ready(out_ready), .out_pc(pc64), .out_type(type64), .out_alu_op(alu64),
        .out_rs1(rs1_64), .out_rs2(rs2_64), .out_rd(rd64), .out_ren_rs1(ren1_64),
        .out_ren_rs2(ren2_64), .out_wen_rd(wen64), .out_imm(imm64), .out_word(word64)
    );

    ysyx_22040365_idu #(.XLEN(32)) dut32 (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(rdy32),
        .in_inst(in_inst), .in_pc(in_pc[31:0]), .flush(flush), .out_valid(vld32),
        .out_ready(out_ready), .out_pc(pc32), .out_type(type32), .out_alu_op(alu32),
        .out_rs1(rs1_32), .out_rs2(rs2_32), .out_rd(rd32), .out_ren_rs1(ren1_32),
        .out_ren_rs2(ren2_32), .out_wen_rd(wen32), .out_imm(imm32), .out_word(word32)
    );

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic send(input logic [31:0] inst, input logic [63:0] pc);
        in_valid = 1'b1;
        in_inst  = inst;
        in_pc    = pc;
        step();
    endtask

    initial begin
        rst_n = 1'b0; in_valid = 1'b0; flush = 1'b0; out_ready = 1'b1;
        in_inst = '0; in_pc = '0;
        #2;
        chk("rst_valid", {63'b0, vld64}, 64'd0);
        chk("rst_in_ready", {63'b0, rdy64}, 64'd1);
        chk("rst_type", {60'b0, type64}, 64'd0);
        chk("rst_imm", imm64, 64'd0);
        chk("rst_valid32", {63'b0, vld32}, 64'd0);
        repeat (2) step();
        rst_n = 1'b1;

        // addi x1,x0,5
        send(32'h0050_0093, 64'h1000);
        chk("addi_valid", {63'b0, vld64}, 64'd1);
        chk("addi_pc", pc64, 64'h1000);
        chk("addi_type", {60'b0, type64}, T_ALU_I);
        chk("addi_alu", {59'b0, alu64}, A_ADD);
        chk("addi_rs1", {59'b0, rs1_64}, 64'd0);
        chk("addi_rd", {59'b0, rd64}, 64'd1);
        chk("addi_imm", imm64, 64'd5);
        chk("addi_ren1", {63'b0, ren1_64}, 64'd1);
        chk("addi_wen", {63'b0, wen64}, 64'd1);
        chk("addi_ren2", {63'b0, ren2_64}, 64'd0);
        chk("addi_word", {63'b0, word64}, 64'd0);
        chk("addi_imm32", {32'b0, imm32}, 64'd5);
        chk("addi_type32", {60'b0, type32}, T_ALU_I);

        // addi x2,x1,-1
        send(32'hFFF0_8113, 64'h1004);
        chk("addim1_imm", imm64, 64'hFFFF_FFFF_FFFF_FFFF);
        chk("addim1_rs1", {59'b0, rs1_64}, 64'd1);
        chk("addim1_rd", {59'b0, rd64}, 64'd2);
        chk("addim1_imm32", {32'b0, imm32}, 64'hFFFF_FFFF);

        // sd x2,8(x1): legal only on RV64
        send(32'h0020_B423, 64'h1008);
        chk("sd_type", {60'b0, type64}, T_STORE);
        chk("sd_imm", imm64, 64'd8);
        chk("sd_rs1", {59'b0, rs1_64}, 64'd1);
        chk("sd_rs2", {59'b0, rs2_64}, 64'd2);
        chk("sd_wen", {63'b0, wen64}, 64'd0);
        chk("sd_ren2", {63'b0, ren2_64}, 64'd1);
        chk("sd_type32", {60'b0, type32}, T_ILLEGAL);
        chk("sd_ren1_32", {63'b0, ren1_32}, 64'd0);

        // addiw x1,x1,1
        send(32'h0010_809B, 64'h100C);
        chk("addiw_type", {60'b0, type64}, T_ALU_I);
        chk("addiw_word", {63'b0, word64}, 64'd1);
        chk("addiw_imm", imm64, 64'd1);
        chk("addiw_type32", {60'b0, type32}, T_ILLEGAL);
        chk("addiw_en32", {61'b0, ren1_32, ren2_32, wen32}, 64'd0);
        chk("addiw_word32", {63'b0, word32}, 64'd0);
        chk("addiw_imm32", {32'b0, imm32}, 64'd0);

        // sub x3,x1,x2
        send(32'h4020_81B3, 64'h1010);
        chk("sub_type", {60'b0, type64}, T_ALU_R);
        chk("sub_alu", {59'b0, alu64}, A_SUB);
        chk("sub_en", {61'b0, ren1_64, ren2_64, wen64}, 64'b111);
        chk("sub_rd", {59'b0, rd64}, 64'd3);
        chk("sub_imm", imm64, 64'd0);

        // beq x0,x0,-8: rd field is nonzero but branches never write
        send(32'hFE00_0CE3, 64'h1014);
        chk("beq_type", {60'b0, type64}, T_BRANCH);
        chk("beq_alu", {59'b0, alu64}, A_BEQ);
        chk("beq_imm", imm64, 64'hFFFF_FFFF_FFFF_FFF8);
        chk("beq_wen", {63'b0, wen64}, 64'd0);
        chk("beq_imm32", {32'b0, imm32}, 64'hFFFF_FFF8);

        // lui x5,0x80000: U-immediate with bit 31 set
        send(32'h8000_02B7, 64'h1018);
        chk("lui_type", {60'b0, type64}, T_LUI);
        chk("lui_imm", imm64, 64'hFFFF_FFFF_8000_0000);
        chk("lui_ren1", {63'b0, ren1_64}, 64'd0);
        chk("lui_wen_rd", {58'b0, wen64, rd64}, {58'b0, 1'b1, 5'd5});
        chk("lui_imm32", {32'b0, imm32}, 64'h8000_0000);

        // jal x1,+16
        send(32'h0100_00EF, 64'h101C);
        chk("jal_type", {60'b0, type64}, T_JAL);
        chk("jal_imm", imm64, 64'd16);
        chk("jal_en", {61'b0, ren1_64, ren2_64, wen64}, 64'b001);

        // addi x0,x0,0: rd=x0 suppresses the write
        send(32'h0000_0013, 64'h1020);
        chk("nop_wen", {63'b0, wen64}, 64'd0);
        chk("nop_ren1", {63'b0, ren1_64}, 64'd1);

        // srai x1,x1,32: 6-bit shamt legal on RV64, illegal on RV32
        send(32'h4200_D093, 64'h1024);
        chk("srai_type", {60'b0, type64}, T_ALU_I);
        chk("srai_alu", {59'b0, alu64}, A_SRA);
        chk("srai_type32", {60'b0, type32}, T_ILLEGAL);
        chk("srai_wen32", {63'b0, wen32}, 64'd0);

        // backpressure: hold bundle at 0x2000 for three cycles
        send(32'h0050_0093, 64'h2000);
        out_ready = 1'b0;
        in_inst   = 32'hFFF0_8113;
        in_pc     = 64'h2004;
        #1;
        chk("bp_in_ready", {63'b0, rdy64}, 64'd0);
        for (int i = 0; i < 3; i++) begin
            step();
            chk("bp_hold_valid", {63'b0, vld64}, 64'd1);
            chk("bp_hold_pc", pc64, 64'h2000);
            chk("bp_hold_imm", imm64, 64'd5);
            chk("bp_hold_rd", {59'b0, rd64}, 64'd1);
            chk("bp_hold_in_ready", {63'b0, rdy64}, 64'd0);
        end
        out_ready = 1'b1;
        #1;
        chk("bp_release_in_ready", {63'b0, rdy64}, 64'd1);
        step();
        chk("bp_next_pc", pc64, 64'h2004);
        chk("bp_next_imm", imm64, 64'hFFFF_FFFF_FFFF_FFFF);
        send(32'h0020_B423, 64'h2008);
        chk("bp_third_pc", pc64, 64'h2008);
        chk("bp_third_valid", {63'b0, vld64}, 64'd1);
        in_valid = 1'b0;
        step();
        chk("bp_drain_valid", {63'b0, vld64}, 64'd0);

        // flush while holding with a new instruction offered
        send(32'h0050_0093, 64'h3000);
        out_ready = 1'b0;
        in_inst   = 32'h8000_02B7;
        in_pc     = 64'h3004;
        flush     = 1'b1;
        step();
        chk("flush_valid", {63'b0, vld64}, 64'd0);
        chk("flush_valid32", {63'b0, vld32}, 64'd0);
        flush = 1'b0;
        step();
        chk("post_flush_pc", pc64, 64'h3004);
        chk("post_flush_type", {60'b0, type64}, T_LUI);

        // reset asserted mid-stall
        in_inst = 32'h0100_00EF;
        in_pc   = 64'h4000;
        step();
        chk("stall_pc", pc64, 64'h3004);
        #2;
        rst_n = 1'b0;
        #1;
        chk("midrst_valid", {63'b0, vld64}, 64'd0);
        chk("midrst_pc", pc64, 64'd0);
        chk("midrst_type", {60'b0, type64}, 64'd0);
        chk("midrst_imm", imm64, 64'd0);
        chk("midrst_rd_en", {56'b0, rd64, ren1_64, ren2_64, wen64}, 64'd0);
        chk("midrst_in_ready", {63'b0, rdy64}, 64'd1);
        step();
        rst_n     = 1'b1;
        out_ready = 1'b1;

        // ebreak after recovery
        send(32'h0010_0073, 64'h5000);
        chk("ebreak_type", {60'b0, type64}, T_EBREAK);
        chk("ebreak_pc", pc64, 64'h5000);
        chk("ebreak_en", {61'b0, ren1_64, ren2_64, wen64}, 64'd0);
        chk("ebreak_imm", imm64, 64'd0);
        chk("ebreak_type32", {60'b0, type32}, T_EBREAK);
        chk("ebreak_pc32", {32'b0, pc32}, 64'h5000);
        in_valid = 1'b0;
        step();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
